// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scanner
// Description : Time-multiplexes four BCD digits onto one shared BCD-to-7-seg
//               encoder for a common-anode 4-digit display. A shadow copy of
//               the digits is taken once per frame so a frame never mixes old
//               and new values. Each digit slot opens with a dead time in
//               which every digit is off, to suppress ghosting. Leading zeros
//               can be blanked, and non-BCD codes are always blanked.
// Ports       : clk        - system clock, rising edge
//               reset_n    - asynchronous active-low reset
//               en         - scan enable; 0 freezes the scan, blanks display
//               digits     - d3..d0 = digits[15:12]..digits[3:0]
//               lz_blank   - 1 = blank leading zeros (d0 never blanked)
//               bcd        - BCD code to the encoder (4'hF when blank)
//               Vs         - 1 = bcd is a digit to display
//               dig_n      - active-low one-hot digit enable
//               frame_done - one-cycle pulse on the slot 3 -> 0 wrap
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic        lz_blank,
  output logic [3:0]  bcd,
  output logic        Vs,
  output logic [3:0]  dig_n,
  output logic        frame_done
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    slot, slot_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic          wrap;

  logic [3:0]    nib;
  logic          upper_zero;
  logic [3:0]    bcd_nxt;
  logic          vs_nxt;
  logic [3:0]    dig_nxt;

  // Next-state: prescaler, slot counter and once-per-frame capture.
  // With en low nothing advances, so a wrap coinciding with en falling is
  // simply not taken.
  always_comb begin
    cnt_nxt    = cnt;
    slot_nxt   = slot;
    shadow_nxt = shadow;
    wrap       = 1'b0;
    if (en) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt  = '0;
        slot_nxt = slot + 2'd1;
        if (slot == 2'd3) begin
          shadow_nxt = digits;
          wrap       = 1'b1;
        end
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Outputs are decoded from the next state so that the registered outputs
  // line up exactly with the registered cnt/slot.
  always_comb begin
    nib = shadow_nxt[{slot_nxt, 2'b00} +: 4];

    // A digit is a leading zero when it and every more significant digit
    // are zero; slot 0 is never considered leading.
    case (slot_nxt)
      2'd3:    upper_zero = (shadow_nxt[15:12] == 4'h0);
      2'd2:    upper_zero = (shadow_nxt[15:8]  == 8'h00);
      2'd1:    upper_zero = (shadow_nxt[15:4]  == 12'h000);
      default: upper_zero = 1'b0;
    endcase

    bcd_nxt = 4'hF;
    vs_nxt  = 1'b0;
    dig_nxt = 4'b1111;
    if (en && (cnt_nxt >= BLANK_END) && (nib <= 4'd9) &&
        !(lz_blank && upper_zero)) begin
      bcd_nxt = nib;
      vs_nxt  = 1'b1;
      dig_nxt = ~(4'b0001 << slot_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      slot       <= 2'd0;
      shadow     <= 16'h0000;
      bcd        <= 4'hF;
      Vs         <= 1'b0;
      dig_n      <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      slot       <= slot_nxt;
      shadow     <= shadow_nxt;
      bcd        <= bcd_nxt;
      Vs         <= vs_nxt;
      dig_n      <= dig_nxt;
      frame_done <= wrap;
    end
  end

endmodule
`default_nettype wire
